// File: rtl/pc_branch_unit_if.sv
// Next-PC request/response bundle between the sequencer and pc_branch_unit.
// The master drives the operation and the slave returns the PC and status.
interface pc_branch_unit_if #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic          en;
    logic          f_in;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic          halted;
    logic          stack_err;
    logic [DW-1:0] depth;

    modport master (output en, f_in, op, target, input  pc, halted, stack_err, depth);
    modport slave  (input  en, f_in, op, target, output pc, halted, stack_err, depth);
endinterface

// File: rtl/pc_branch_unit.sv
// Program-counter stage: sequential / jump / flag branch / call / return,
// with a small return-address stack. HALT and stack misuse park it until reset.
module pc_branch_unit #(
    parameter int            AW       = 8,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst_n,
    pc_branch_unit_if.slave   bus
);
    localparam int            DW   = $clog2(DEPTH + 1);
    localparam int            AIW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRT  = 3'b010;
    localparam logic [2:0] OP_BRF  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [AW-1:0] stack_q [DEPTH];

    logic [AW-1:0]  pc_inc;
    logic [AIW-1:0] push_idx, pop_idx;
    logic           push;

    // Return address wraps the same way as a sequential step.
    assign pc_inc   = pc_q + AW'(1);
    assign push_idx = AIW'(depth_q);
    assign pop_idx  = AIW'(depth_q - DW'(1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        if (bus.en && state_q == RUN) begin
            unique case (bus.op)
                OP_JMP:  pc_d = bus.target;
                OP_BRT:  pc_d = bus.f_in ? bus.target : pc_inc;
                OP_BRF:  pc_d = bus.f_in ? pc_inc : bus.target;
                OP_CALL: begin
                    if (depth_q == FULL) begin
                        state_d = FAULT;
                    end else begin
                        push    = 1'b1;
                        pc_d    = bus.target;
                        depth_d = depth_q + DW'(1);
                    end
                end
                OP_RET: begin
                    if (depth_q == '0) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = stack_q[pop_idx];
                        depth_d = depth_q - DW'(1);
                    end
                end
                OP_HALT: state_d = HALTED;
                default: pc_d = pc_inc;  // SEQ and the reserved encoding
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            depth_q <= depth_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= pc_inc;
    end

    assign bus.pc        = pc_q;
    assign bus.depth     = depth_q;
    assign bus.halted    = (state_q == HALTED);
    assign bus.stack_err = (state_q == FAULT);

    logic unused_op;
    assign unused_op = (bus.op == OP_SEQ);
endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed vector bench for pc_branch_unit (AW=8, DEPTH=4, RESET_PC=0).
module tb_pc_branch_unit;
    localparam int AW = 8, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_branch_unit_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

    pc_branch_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       r;
        logic       en;
        logic       f;
        logic [2:0] op;
        logic [7:0] tgt;
        logic [7:0] pc;
        logic       h;
        logic       e;
        logic [2:0] d;
    } vec_t;

    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BRT = 3'd2, BRF = 3'd3,
                           CALL = 3'd4, RET = 3'd5, HALT = 3'd6, RSV = 3'd7;

    vec_t tv[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void v(logic r, logic en, logic f, logic [2:0] op, logic [7:0] tgt,
                              logic [7:0] pc, logic h, logic e, logic [2:0] d);
        vec_t t;
        t.r = r; t.en = en; t.f = f; t.op = op; t.tgt = tgt;
        t.pc = pc; t.h = h; t.e = e; t.d = d;
        tv.push_back(t);
    endfunction

    task automatic check(string name, int idx, vec_t t);
        checks++;
        if (bus.pc !== t.pc || bus.halted !== t.h || bus.stack_err !== t.e || bus.depth !== t.d) begin
            errors++;
            $display("FAIL %s row %0d: got pc=%h halted=%b stack_err=%b depth=%0d, want pc=%h halted=%b stack_err=%b depth=%0d",
                     name, idx, bus.pc, bus.halted, bus.stack_err, bus.depth, t.pc, t.h, t.e, t.d);
        end
    endtask

    initial begin
        //  r  en f  op    tgt     pc     h  e  d
        v(1, 1, 0, SEQ,  8'h00, 8'h00, 0, 0, 0);   // reset state
        v(0, 1, 0, SEQ,  8'h00, 8'h01, 0, 0, 0);
        v(0, 1, 0, SEQ,  8'h00, 8'h02, 0, 0, 0);
        v(0, 1, 0, SEQ,  8'h00, 8'h03, 0, 0, 0);
        v(1, 1, 0, SEQ,  8'h00, 8'h00, 0, 0, 0);   // mid-run reset
        v(0, 1, 1, BRT,  8'h40, 8'h40, 0, 0, 0);
        v(0, 1, 0, BRT,  8'h40, 8'h41, 0, 0, 0);
        v(0, 1, 0, BRF,  8'h40, 8'h40, 0, 0, 0);
        v(0, 1, 1, BRF,  8'h40, 8'h41, 0, 0, 0);
        v(0, 1, 0, RSV,  8'h77, 8'h42, 0, 0, 0);
        v(0, 1, 0, JMP,  8'hFF, 8'hFF, 0, 0, 0);
        v(0, 1, 0, SEQ,  8'h00, 8'h00, 0, 0, 0);   // wrap
        v(0, 1, 0, JMP,  8'hFF, 8'hFF, 0, 0, 0);
        v(0, 1, 0, CALL, 8'h20, 8'h20, 0, 0, 1);   // pushes 00
        v(0, 1, 0, RET,  8'h00, 8'h00, 0, 0, 0);
        v(0, 1, 0, CALL, 8'h30, 8'h30, 0, 0, 1);   // pushes 01
        v(0, 0, 1, JMP,  8'h10, 8'h30, 0, 0, 1);   // en=0 hold x3
        v(0, 0, 0, JMP,  8'h10, 8'h30, 0, 0, 1);
        v(0, 0, 1, CALL, 8'h10, 8'h30, 0, 0, 1);
        v(0, 1, 0, RET,  8'h00, 8'h01, 0, 0, 0);
        v(0, 1, 0, CALL, 8'h50, 8'h50, 0, 0, 1);   // pushes 02
        v(0, 1, 0, CALL, 8'h50, 8'h50, 0, 0, 2);   // self-call pushes 51
        v(0, 1, 0, CALL, 8'h60, 8'h60, 0, 0, 3);   // pushes 51
        v(0, 1, 0, CALL, 8'h70, 8'h70, 0, 0, 4);   // pushes 61
        v(0, 1, 0, RET,  8'h00, 8'h61, 0, 0, 3);
        v(0, 1, 0, RET,  8'h00, 8'h51, 0, 0, 2);
        v(0, 1, 0, RET,  8'h00, 8'h51, 0, 0, 1);
        v(0, 1, 0, CALL, 8'h90, 8'h90, 0, 0, 2);
        v(0, 1, 0, CALL, 8'h91, 8'h91, 0, 0, 3);
        v(0, 1, 0, CALL, 8'h92, 8'h92, 0, 0, 4);
        v(0, 1, 0, CALL, 8'hA0, 8'h92, 0, 1, 4);   // overflow
        v(0, 1, 0, SEQ,  8'h00, 8'h92, 0, 1, 4);
        v(0, 1, 0, RET,  8'h00, 8'h92, 0, 1, 4);
        v(1, 1, 0, SEQ,  8'h00, 8'h00, 0, 0, 0);
        v(0, 1, 0, RET,  8'h00, 8'h00, 0, 1, 0);   // underflow
        v(0, 1, 0, JMP,  8'h10, 8'h00, 0, 1, 0);
        v(1, 1, 0, SEQ,  8'h00, 8'h00, 0, 0, 0);
        v(0, 1, 0, SEQ,  8'h00, 8'h01, 0, 0, 0);
        v(0, 1, 0, HALT, 8'h00, 8'h01, 1, 0, 0);
        v(0, 1, 0, JMP,  8'h10, 8'h01, 1, 0, 0);
        v(0, 1, 0, CALL, 8'h20, 8'h01, 1, 0, 0);
        v(1, 1, 0, SEQ,  8'h00, 8'h00, 0, 0, 0);
        v(0, 1, 1, BRT,  8'h33, 8'h33, 0, 0, 0);

        bus.en = 1'b0; bus.f_in = 1'b0; bus.op = SEQ; bus.target = '0;

        foreach (tv[i]) begin
            @(negedge clk);
            bus.en     = tv[i].en;
            bus.f_in   = tv[i].f;
            bus.op     = tv[i].op;
            bus.target = tv[i].tgt;
            if (tv[i].r) begin
                rst_n = 1'b0;
                #1 check("rst_async", i, tv[i]);
                @(posedge clk);
                #1 check("rst_hold", i, tv[i]);
            end else begin
                rst_n = 1'b1;
                @(posedge clk);
                #1 check("step", i, tv[i]);
            end
        end

        // Async reset landing mid-cycle while stack and pc are non-trivial.
        @(negedge clk);
        rst_n = 1'b1; bus.en = 1'b1; bus.op = CALL; bus.target = 8'h5A;
        @(posedge clk);
        #1 check("call_pre_rst", 900, '{0, 1, 0, CALL, 8'h5A, 8'h5A, 0, 0, 1});
        #2 rst_n = 1'b0;
        #1 check("rst_midcycle", 901, '{1, 1, 0, CALL, 8'h5A, 8'h00, 0, 0, 0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
